// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
//   Gshare/bimodal branch direction predictor built on a table of saturating
//   counters, a global history register (GHR) and a mispredict counter.
//   After reset or flush the table is swept to weakly-not-taken, one entry per
//   cycle, before predictions are served.
//
// Ports
//   clk             clock, rising-edge
//   rst_n           asynchronous active-low reset
//   flush           synchronous re-initialisation request
//   lookup_valid    prediction request
//   lookup_pc       low PC bits of the branch
//   pred_taken      predicted direction (0 while not ready)
//   pred_idx        table index used for this lookup
//   pred_ghr        GHR before this lookup (checkpoint)
//   ready           high once the table sweep has completed
//   upd_valid       branch resolution
//   upd_idx         index to train (pred_idx of that branch)
//   upd_taken       resolved outcome
//   upd_mispredict  resolved outcome differed from prediction
//   upd_ghr         checkpoint returned with the resolution
//   mispred_cnt     saturating count of accepted mispredicts
// ---------------------------------------------------------------------------
module branch_predictor_gshare #(
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned HIST_W    = 5,
  parameter int unsigned GSHARE_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_ghr,
  output logic              ready,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [HIST_W-1:0] upd_ghr,
  output logic [15:0]       mispred_cnt
);

  localparam int unsigned    ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] WNT   = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CMAX  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_init_ptr;
  logic [HIST_W-1:0] r_ghr;
  logic [15:0]       r_mispred_cnt;
  logic [CTR_W-1:0]  r_table [ENTRIES];

  logic [IDX_W-1:0]  w_idx;
  logic              w_pred_taken;
  logic              w_lookup_acc;
  logic              w_upd_acc;
  logic [HIST_W-1:0] w_ghr_shift;
  logic [HIST_W-1:0] w_ghr_repair;
  logic [CTR_W-1:0]  w_ctr_old;
  logic [CTR_W-1:0]  w_ctr_new;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_INIT;
    end else if (r_state == ST_INIT && (&r_init_ptr)) begin
      w_state_nxt = ST_RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = (r_state == ST_RUN);
  end

  // ---------------- lookup path ----------------
  always_comb begin
    w_idx = lookup_pc;
    if (GSHARE_EN != 0) w_idx = lookup_pc ^ IDX_W'(r_ghr);
  end

  assign w_pred_taken = ready & r_table[w_idx][CTR_W-1];
  assign pred_taken   = w_pred_taken;
  assign pred_idx     = w_idx;
  assign pred_ghr     = r_ghr;
  assign mispred_cnt  = r_mispred_cnt;

  // flush blocks acceptance so it wins over same-cycle traffic
  assign w_lookup_acc = lookup_valid & ready & ~flush;
  assign w_upd_acc    = upd_valid & ready & ~flush;

  // Truncating casts keep the newest HIST_W bits; this also covers HIST_W=1
  assign w_ghr_shift  = HIST_W'({r_ghr, w_pred_taken});
  assign w_ghr_repair = HIST_W'({upd_ghr, upd_taken});

  // ---------------- counter update ----------------
  assign w_ctr_old = r_table[upd_idx];

  always_comb begin
    w_ctr_new = w_ctr_old;
    if (upd_taken) begin
      if (w_ctr_old != CMAX) w_ctr_new = w_ctr_old + CTR_W'(1);
    end else begin
      if (w_ctr_old != '0)   w_ctr_new = w_ctr_old - CTR_W'(1);
    end
  end

  // ---------------- init pointer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_ptr <= '0;
    end else if (flush) begin
      r_init_ptr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_ptr <= r_init_ptr + IDX_W'(1);
    end
  end

  // ---------------- global history ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (flush) begin
      r_ghr <= '0;
    end else if (w_upd_acc && upd_mispredict) begin
      r_ghr <= w_ghr_repair;
    end else if (w_lookup_acc) begin
      r_ghr <= w_ghr_shift;
    end
  end

  // ---------------- mispredict counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispred_cnt <= '0;
    end else if (w_upd_acc && upd_mispredict && (r_mispred_cnt != '1)) begin
      r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

  // ---------------- counter table (no reset; swept in INIT) ----------------
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (r_state == ST_INIT) begin
        r_table[r_init_ptr] <= WNT;
      end else if (w_upd_acc) begin
        r_table[upd_idx] <= w_ctr_new;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
module tb_branch_predictor_gshare;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       lookup_valid;
  logic [4:0] lookup_pc;
  logic       upd_valid;
  logic [4:0] upd_idx;
  logic       upd_taken;
  logic       upd_mispredict;
  logic [4:0] upd_ghr;

  logic       pred_taken,   b_pred_taken;
  logic [4:0] pred_idx,     b_pred_idx;
  logic [4:0] pred_ghr,     b_pred_ghr;
  logic       ready,        b_ready;
  logic [15:0] mispred_cnt, b_mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor_gshare #(.IDX_W(5), .CTR_W(2), .HIST_W(5), .GSHARE_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr), .ready(ready),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr), .mispred_cnt(mispred_cnt)
  );

  branch_predictor_gshare #(.IDX_W(5), .CTR_W(2), .HIST_W(5), .GSHARE_EN(0)) u_bim (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(b_pred_taken), .pred_idx(b_pred_idx), .pred_ghr(b_pred_ghr), .ready(b_ready),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr), .mispred_cnt(b_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [4:0] idx, input logic tk, input logic mis, input logic [4:0] gh);
    upd_valid      = 1'b1;
    upd_idx        = idx;
    upd_taken      = tk;
    upd_mispredict = mis;
    upd_ghr        = gh;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 40);
    check(tag, n, 32);
  endtask

  bit tk_seq [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
  bit ex_seq [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit ex_lk  [3] = '{1, 0, 1};

  initial begin
    int errs;
    rst_n = 1'b0; flush = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispredict = 1'b0; upd_ghr = '0;

    // reset state
    repeat (2) tick();
    check("rst_ready", ready, 0);
    check("rst_pred", pred_taken, 0);
    check("rst_cnt", mispred_cnt, 0);
    check("rst_ghr", pred_ghr, 0);

    // release: 32-cycle sweep
    rst_n = 1'b1;
    wait_ready("init_len");
    check("init_bim_ready", b_ready, 1);
    errs = 0;
    for (int pc = 0; pc < 32; pc++) begin
      lookup_pc = 5'(pc);
      #1;
      if (pred_taken !== 1'b0 || b_pred_taken !== 1'b0) errs++;
    end
    check("init_all_wnt", errs, 0);

    // saturating counter at index 3 (ghr=0, both instances index 3)
    lookup_pc = 5'd3;
    #1;
    check("bim_idx3", b_pred_idx, 3);
    check("gsh_idx3", pred_idx, 3);
    for (int i = 0; i < 8; i++) begin
      do_upd(5'd3, tk_seq[i], 1'b0, 5'd0);
      check($sformatf("sat_bim_%0d", i), b_pred_taken, ex_seq[i]);
      check($sformatf("sat_gsh_%0d", i), pred_taken, ex_seq[i]);
    end

    // history build-up: train idx 4 and 6 to weakly taken
    do_upd(5'd4, 1'b1, 1'b0, 5'd0);
    do_upd(5'd6, 1'b1, 1'b0, 5'd0);
    lookup_valid = 1'b1;
    lookup_pc    = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lk_pred_%0d", i), pred_taken, ex_lk[i]);
      tick();
    end
    lookup_valid = 1'b0;
    #1;
    check("ghr_00101", pred_ghr, 5'b00101);
    check("gsh_idx_xor", pred_idx, 5'b00001);
    check("bim_ghr_00111", b_pred_ghr, 5'b00111);
    check("bim_idx_pc", b_pred_idx, 5'd4);

    // repair overrides same-cycle shift
    lookup_valid = 1'b1;
    do_upd(5'd20, 1'b0, 1'b1, 5'b10110);
    lookup_valid = 1'b0;
    check("repair_ghr", pred_ghr, 5'b01100);
    check("repair_bim_ghr", b_pred_ghr, 5'b01100);
    check("repair_cnt", mispred_cnt, 1);

    // same-index lookup+update: lookup sees the old counter (idx 9 = 5 ^ 01100)
    lookup_valid = 1'b1;
    lookup_pc    = 5'd5;
    upd_valid = 1'b1; upd_idx = 5'd9; upd_taken = 1'b1; upd_mispredict = 1'b0;
    #1;
    check("byp_idx", pred_idx, 5'd9);
    check("byp_old", pred_taken, 0);
    tick();
    upd_valid = 1'b0; lookup_valid = 1'b0;
    lookup_pc = 5'd17;  // 17 ^ 11000 = 9
    #1;
    check("byp_ghr", pred_ghr, 5'b11000);
    check("byp_idx2", pred_idx, 5'd9);
    check("byp_new", pred_taken, 1);

    // bring mispredict count to 7
    for (int i = 0; i < 6; i++) do_upd(5'd30, 1'b1, 1'b1, 5'd0);
    check("cnt7", mispred_cnt, 7);
    check("cnt7_ghr", pred_ghr, 5'b00001);

    // flush with competing lookup and update; keep them on through INIT
    flush = 1'b1; lookup_valid = 1'b1; lookup_pc = 5'd4;
    upd_valid = 1'b1; upd_idx = 5'd3; upd_taken = 1'b1; upd_mispredict = 1'b1; upd_ghr = 5'b11111;
    tick();
    flush = 1'b0;
    check("flush_ready", ready, 0);
    check("flush_ghr", pred_ghr, 0);
    check("flush_cnt", mispred_cnt, 7);
    wait_ready("flush_init_len");
    lookup_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("init_ign_cnt", mispred_cnt, 7);
    check("init_ign_ghr", pred_ghr, 0);
    lookup_pc = 5'd4;
    #1;
    check("flush_reinit4", pred_taken, 0);

    // asynchronous reset in the middle of INIT
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", ready, 0);
    check("async_cnt", mispred_cnt, 0);
    check("async_ghr", pred_ghr, 0);
    check("async_pred", pred_taken, 0);
    tick();
    rst_n = 1'b1;
    wait_ready("reinit_len");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter IDX_W, default 5: table index width; the table SHALL hold ENTRIES = 2^IDX_W entries.
REQ-002 Parameter CTR_W, default 2: saturating counter width, legal range 2..4.
REQ-003 Parameter HIST_W, default 5: global history register (GHR) width, legal range 1..IDX_W.
REQ-004 Parameter GSHARE_EN, default 1: 1 selects gshare indexing, 0 selects bimodal indexing.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 flush  input  1  synchronous re-initialisation request.
REQ-008 lookup_valid  input  1  prediction request.
REQ-009 lookup_pc  input  IDX_W  low PC bits of the branch.
REQ-010 pred_taken  output  1  prediction; combinational from the current table state.
REQ-011 pred_idx  output  IDX_W  table index used for the lookup; the pipeline returns it on update.
REQ-012 pred_ghr  output  HIST_W  GHR value before this lookup (checkpoint).
REQ-013 ready  output  1  high when in RUN state.
REQ-014 upd_valid  input  1  branch resolution.
REQ-015 upd_idx  input  IDX_W  index to train; equals pred_idx of that branch.
REQ-016 upd_taken  input  1  actual outcome.
REQ-017 upd_mispredict  input  1  outcome differed from the prediction.
REQ-018 upd_ghr  input  HIST_W  checkpoint captured from pred_ghr.
REQ-019 mispred_cnt  output  16  saturating count of mispredicts accepted in RUN.

Function
REQ-020 Index: pred_idx = lookup_pc XOR zero-extended GHR when GSHARE_EN=1, else lookup_pc.
REQ-021 pred_taken = MSB of the counter at pred_idx when ready=1; 0 when ready=0.
REQ-022 FSM states: INIT and RUN; rst_n low or flush high SHALL force INIT, with init_ptr=0 and GHR=0.
REQ-023 INIT: one entry per cycle, entry[init_ptr] <= WNT = 2^(CTR_W-1)-1, init_ptr increments.
REQ-024 INIT -> RUN on the cycle that writes entry ENTRIES-1; ready rises the following cycle, so INIT lasts exactly ENTRIES cycles.
REQ-025 In INIT, lookups and updates SHALL be ignored: no GHR, table or mispred_cnt change.
REQ-026 flush in RUN or INIT SHALL restart INIT from init_ptr=0 in the next cycle, and SHALL take priority over same-cycle lookups and updates.
REQ-027 Lookup accepted (lookup_valid & ready) SHALL shift GHR: GHR <= {GHR[HIST_W-2:0], pred_taken} (HIST_W=1: GHR <= pred_taken).
REQ-028 Update accepted (upd_valid & ready) SHALL write the counter at upd_idx: increment, saturating at 2^CTR_W-1, if upd_taken; otherwise decrement, saturating at 0.
REQ-029 Accepted update with upd_mispredict=1 SHALL repair GHR <= {upd_ghr[HIST_W-2:0], upd_taken}; repair overrides a same-cycle lookup shift.
REQ-030 Lookup and update in the same cycle to the same index: the lookup SHALL see the pre-update counter; the write takes effect at the edge.
REQ-031 mispred_cnt SHALL increment on each accepted update with upd_mispredict=1, hold at 16'hFFFF, and clear only on rst_n (not on flush).
REQ-032 With GSHARE_EN=0 the GHR SHALL still track and repair per REQ-027/029, but it SHALL NOT affect indexing.

Reset
REQ-033 While rst_n=0: state=INIT, init_ptr=0, GHR=0, mispred_cnt=0, ready=0, pred_taken=0; table contents are undefined until INIT completes.
REQ-034 The first INIT write SHALL occur on the first rising edge after rst_n deasserts.
REQ-035 Assertion of rst_n mid-INIT or mid-RUN SHALL take effect immediately without waiting for clk.

Verification (IDX_W=5, CTR_W=2, HIST_W=5)
REQ-036 Release reset -> ready=0 for exactly 32 cycles, then 1; every entry reads 2'b01 and pred_taken=0.
REQ-037 GSHARE_EN=0, idx 3: update taken x3 -> counter 01->10->11->11 (saturates) and pred_taken=1; not-taken x4 -> 11->10->01->00->00.
REQ-038 GHR=5'b00000, lookups at pc 4 with predictions 1,0,1 -> GHR=5'b00101; next lookup at pc 4 gives pred_idx=5'b00001.
REQ-039 Same-cycle lookup and update with upd_mispredict=1, upd_ghr=5'b10110, upd_taken=0 -> GHR=5'b01100 (repair wins over the shift).
REQ-040 Flush mid-RUN with mispred_cnt=7 -> ready drops next cycle, GHR=0, 32-cycle INIT follows, mispred_cnt stays 7; drive rst_n low mid-INIT -> ready=0 and mispred_cnt=0 at once.
REQ-041 Same-index lookup and update in one cycle, counter=01, upd_taken=1 -> pred_taken=0 that cycle, 1 the next cycle.
